// File: rtl/bsg_idiv_iterative_share_rr.sv
// Round-robin arbiter that time-shares one iterative divider among els_p requesters.
// Optional BSG_IDIV_SHARE_ZERO_BYPASS_EN answers zero-divisor ops locally without the divider.
module bsg_idiv_iterative_share_rr #(
    parameter int unsigned width_p = 32,
    parameter int unsigned els_p   = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,

    input  logic [els_p-1:0]           v_i,
    output logic [els_p-1:0]           ready_and_o,
    input  logic [els_p*width_p-1:0]   dividend_i,
    input  logic [els_p*width_p-1:0]   divisor_i,
    input  logic [els_p-1:0]           signed_div_i,

    output logic [els_p-1:0]           v_o,
    output logic [width_p-1:0]         quotient_o,
    output logic [width_p-1:0]         remainder_o,
    input  logic [els_p-1:0]           yumi_i,

    output logic                       div_v_o,
    input  logic                       div_ready_and_i,
    output logic [width_p-1:0]         div_dividend_o,
    output logic [width_p-1:0]         div_divisor_o,
    output logic                       div_signed_div_o,
    input  logic                       div_v_i,
    input  logic [width_p-1:0]         div_quotient_i,
    input  logic [width_p-1:0]         div_remainder_i,
    output logic                       div_yumi_o
);

    localparam int unsigned IdW = (els_p > 1) ? $clog2(els_p) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StBusy, StResp} state_e;

    state_e               state_q, state_d;
    logic [IdW-1:0]       ptr_q, id_q;
    logic [width_p-1:0]   dividend_q, divisor_q, quotient_q, remainder_q;
    logic                 signed_q;

    logic [IdW-1:0]       grant, ptr_next;
    logic                 found, accept, bypass;
    logic [width_p-1:0]   sel_dividend, sel_divisor;
    int unsigned          idx;

    // Rotating priority search starting at ptr_q.
    always_comb begin
        found    = 1'b0;
        grant    = '0;
        ptr_next = ptr_q;
        idx      = 0;
        for (int unsigned i = 0; i < els_p; i++) begin
            idx = (32'(ptr_q) + i) % els_p;
            if (!found && v_i[idx]) begin
                found    = 1'b1;
                grant    = IdW'(idx);
                ptr_next = IdW'((idx + 1) % els_p);
            end
        end
    end

    assign sel_dividend = dividend_i[32'(grant)*width_p +: width_p];
    assign sel_divisor  = divisor_i[32'(grant)*width_p +: width_p];
    assign accept       = (state_q == StIdle) && found;

`ifdef BSG_IDIV_SHARE_ZERO_BYPASS_EN
    assign bypass = (sel_divisor == '0);
`else
    assign bypass = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = bypass ? StResp : StIssue;
            StIssue: if (div_ready_and_i) state_d = StBusy;
            StBusy:  if (div_v_i) state_d = StResp;
            StResp:  if (yumi_i[id_q]) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready_and_o = '0;
        v_o         = '0;
        div_v_o     = 1'b0;
        div_yumi_o  = 1'b0;
        // Gated by reset so v_i / div_v_i cannot leak through while held in reset.
        if (reset_n_i) begin
            unique case (state_q)
                StIdle:  if (found) ready_and_o[grant] = 1'b1;
                StIssue: div_v_o = 1'b1;
                StBusy:  div_yumi_o = div_v_i;
                StResp:  v_o[id_q] = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_q       <= '0;
            id_q        <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            signed_q    <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else if (accept) begin
            ptr_q      <= ptr_next;
            id_q       <= grant;
            dividend_q <= sel_dividend;
            divisor_q  <= sel_divisor;
            signed_q   <= signed_div_i[grant];
            if (bypass) begin
                quotient_q  <= '1;
                remainder_q <= sel_dividend;
            end
        end else if (state_q == StBusy && div_v_i) begin
            quotient_q  <= div_quotient_i;
            remainder_q <= div_remainder_i;
        end
    end

    assign quotient_o       = quotient_q;
    assign remainder_o      = remainder_q;
    assign div_dividend_o   = dividend_q;
    assign div_divisor_o    = divisor_q;
    assign div_signed_div_o = signed_q;

endmodule

// File: tb/tb_bsg_idiv_iterative_share_rr.sv
// Directed bench for bsg_idiv_iterative_share_rr; the divider side is driven by hand.
module tb_bsg_idiv_iterative_share_rr;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   v = '0, ready_and, v_out, yumi = '0, sgn = '0;
    logic [N*W-1:0] dividend = '0, divisor = '0;
    logic [W-1:0]   quotient, remainder, div_dividend, div_divisor;
    logic [W-1:0]   div_q = '0, div_r = '0;
    logic           div_v_out, div_ready = 1'b1, div_signed, div_v_in = 1'b0, div_yumi;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bsg_idiv_iterative_share_rr #(.width_p(W), .els_p(N)) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .v_i             (v),
        .ready_and_o     (ready_and),
        .dividend_i      (dividend),
        .divisor_i       (divisor),
        .signed_div_i    (sgn),
        .v_o             (v_out),
        .quotient_o      (quotient),
        .remainder_o     (remainder),
        .yumi_i          (yumi),
        .div_v_o         (div_v_out),
        .div_ready_and_i (div_ready),
        .div_dividend_o  (div_dividend),
        .div_divisor_o   (div_divisor),
        .div_signed_div_o(div_signed),
        .div_v_i         (div_v_in),
        .div_quotient_i  (div_q),
        .div_remainder_i (div_r),
        .div_yumi_o      (div_yumi)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called just after a negedge in IDLE; returns just after a negedge back in IDLE.
    task automatic run_op(input int g, input logic [N-1:0] vmask, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic s, input logic [W-1:0] q,
                          input logic [W-1:0] r, input int issue_wait, input int resp_wait);
        logic [N-1:0] exp_hot;
        exp_hot = N'(1) << g;
        v = vmask;
        dividend[g*W +: W] = a;
        divisor[g*W +: W]  = b;
        sgn[g] = s;
        #1 chk("grant", 64'(ready_and), 64'(exp_hot));
        cyc();
        if (vmask == exp_hot) v = '0;
        chk("issue_v", 64'(div_v_out), 64'd1);
        chk("issue_dividend", 64'(div_dividend), 64'(a));
        chk("issue_divisor", 64'(div_divisor), 64'(b));
        chk("issue_signed", 64'(div_signed), 64'(s));
        div_ready = (issue_wait == 0);
        for (int i = 0; i < issue_wait; i++) begin
            cyc();
            chk("issue_hold", 64'(div_v_out), 64'd1);
            chk("issue_no_accept", 64'(ready_and), 64'd0);
            if (i == issue_wait - 1) div_ready = 1'b1;
        end
        cyc();
        chk("busy_div_v", 64'(div_v_out), 64'd0);
        div_v_in = 1'b1;
        div_q = q;
        div_r = r;
        #1 chk("busy_yumi", 64'(div_yumi), 64'd1);
        cyc();
        div_v_in = 1'b0;
        chk("resp_v", 64'(v_out), 64'(exp_hot));
        chk("resp_q", 64'(quotient), 64'(q));
        chk("resp_r", 64'(remainder), 64'(r));
        for (int i = 0; i < resp_wait; i++) begin
            cyc();
            chk("resp_hold_v", 64'(v_out), 64'(exp_hot));
            chk("resp_hold_q", 64'(quotient), 64'(q));
            chk("resp_hold_r", 64'(remainder), 64'(r));
            chk("resp_no_accept", 64'(ready_and), 64'd0);
        end
        yumi = exp_hot;
        cyc();
        yumi = '0;
        chk("resp_done", 64'(v_out), 64'd0);
    endtask

    initial begin
        // Outputs held at zero during reset even with requests pending.
        v = 4'b0100;
        dividend[2*W +: W] = 32'd100;
        #12;
        chk("rst_ready", 64'(ready_and), 64'd0);
        chk("rst_v_o", 64'(v_out), 64'd0);
        chk("rst_div_v", 64'(div_v_out), 64'd0);
        chk("rst_div_dividend", 64'(div_dividend), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single op with stall checks; wrong-bit yumi must be ignored.
        v = 4'b0100;
        dividend[2*W +: W] = 32'd100;
        divisor[2*W +: W]  = 32'd7;
        #1 chk("single_grant", 64'(ready_and), 64'h4);
        cyc();
        v = '0;
        chk("single_issue", 64'(div_v_out), 64'd1);
        chk("single_dividend", 64'(div_dividend), 64'd100);
        cyc();
        div_v_in = 1'b1;
        div_q = 32'd14;
        div_r = 32'd2;
        cyc();
        div_v_in = 1'b0;
        yumi = 4'b0001;
        cyc();
        chk("single_ignore_yumi", 64'(v_out), 64'h4);
        chk("single_q", 64'(quotient), 64'd14);
        chk("single_r", 64'(remainder), 64'd2);
        yumi = 4'b0100;
        cyc();
        yumi = '0;
        chk("single_done", 64'(v_out), 64'd0);
        v = 4'hF;
        #1 chk("ptr_after_single", 64'(ready_and), 64'h8);
        v = '0;

        // Fairness from ptr 0.
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++)
            run_op(k % N, 4'hF, 32'(k + 10), 32'd3, 1'b0, 32'(k), 32'(k + 1), 0, 0);
        v = '0;

        // Back-pressure on both sides.
        run_op(3, 4'b1000, 32'd1000, 32'd9, 1'b0, 32'd111, 32'd1, 5, 10);

        // Signed op forwarded unchanged.
        run_op(1, 4'b0010, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0);

        // Zero divisor.
`ifdef BSG_IDIV_SHARE_ZERO_BYPASS_EN
        v = 4'b0001;
        dividend[0 +: W] = 32'd55;
        divisor[0 +: W]  = 32'd0;
        #1 chk("zero_grant", 64'(ready_and), 64'h1);
        cyc();
        v = '0;
        chk("zero_v_o", 64'(v_out), 64'h1);
        chk("zero_q", 64'(quotient), 64'hFFFF_FFFF);
        chk("zero_r", 64'(remainder), 64'd55);
        chk("zero_no_div", 64'(div_v_out), 64'd0);
        yumi = 4'b0001;
        cyc();
        yumi = '0;
        chk("zero_done", 64'(v_out), 64'd0);
`else
        run_op(0, 4'b0001, 32'd55, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd55, 0, 0);
`endif

        // Reset while BUSY.
        v = 4'b1000;
        dividend[3*W +: W] = 32'd77;
        divisor[3*W +: W]  = 32'd5;
        cyc();
        v = 4'hF;
        cyc();
        chk("mid_busy", 64'(div_v_out), 64'd0);
        div_v_in = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_yumi", 64'(div_yumi), 64'd0);
        chk("mid_rst_v_o", 64'(v_out), 64'd0);
        chk("mid_rst_ready", 64'(ready_and), 64'd0);
        chk("mid_rst_dividend", 64'(div_dividend), 64'd0);
        div_v_in = 1'b0;
        cyc();
        reset_n = 1'b1;
        #1 chk("post_rst_grant", 64'(ready_and), 64'h1);
        chk("post_rst_v_o", 64'(v_out), 64'd0);
        v = '0;
        cyc();
        chk("post_rst_idle", 64'(div_v_out), 64'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
